sad_min_scanner: RTL and testbench
==================================

Name: sad_min_scanner

Overview:
- Sequential reducer for the eight SAD motion-search cores. It snapshots each core's (SAD, row, column, valid) result on Start and scans one core per clock, keeping a running minimum.
- Adds the per-core row offset (core index × ROW_STRIDE) to each row.
- Presents the winning (SAD, row, column) through a valid/ready handshake to the min-SAD register and display path.
- Replaces the combinational comparator tree with a small serial datapath.

Parameters:
- NUM_CORES, 8, number of core result slots scanned.
- SAD_W, 32, SAD value width.
- COORD_W, 8, row/column width.
- ROW_STRIDE, 8, row offset added per core index.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset, synchronous, active-low.
- Start  in  1  single-cycle request to snapshot inputs and begin a scan.
- CoreSAD  in  NUM_CORES*SAD_W  packed SADs; slot i occupies [i*SAD_W +: SAD_W].
- CoreRow  in  NUM_CORES*COORD_W  packed local rows, one per core.
- CoreCol  in  NUM_CORES*COORD_W  packed columns, one per core.
- CoreValid  in  NUM_CORES  per-core result valid.
- OutReady  in  1  consumer accepts the result.
- OutValid  out  1  result available.
- MinSAD  out  SAD_W  winning SAD.
- MinRow  out  COORD_W  winning global row.
- MinCol  out  COORD_W  winning column.
- AnyValid  out  1  at least one valid slot in the scanned snapshot.
- Busy  out  1  high in SCAN or HOLD.

Behaviour:
- States:
  - IDLE→SCAN on Start.
  - SCAN→HOLD after slot NUM_CORES-1 is evaluated.
  - HOLD→IDLE when OutValid && OutReady.
- Rst low at a clock edge:
  - State goes to IDLE.
  - OutValid, Busy, AnyValid, MinSAD, MinRow and MinCol all go to 0.
  - The snapshot registers and index are cleared.
  - Rst overrides everything, including a scan in progress.
- Start sampled high in IDLE, at edge E:
  - Latch all CoreSAD, CoreRow, CoreCol and CoreValid into the snapshot.
  - Set index=0, best=all ones, bestRow=0, bestCol=0, found=0.
  - Scanning uses only the snapshot; later input changes have no effect.
- Start in SCAN or HOLD is ignored and not queued.
- SCAN, one slot per edge (edges E+1 … E+NUM_CORES evaluate slots 0 … NUM_CORES-1):
  - Update when CoreValid[i] && (!found || SAD[i] < best): best=SAD[i], bestRow=(Row[i] + i*ROW_STRIDE) mod 2^COORD_W, bestCol=Col[i], found=1.
  - Comparison is strict unsigned less-than, so on a tie the lower index wins.
  - Invalid slots never update the running best, regardless of their SAD.
- Entering HOLD, at edge E+NUM_CORES:
  - MinSAD/MinRow/MinCol are loaded from best/bestRow/bestCol.
  - AnyValid is loaded from found; OutValid goes to 1.
  - Latency: OutValid is high in the cycle after edge E+NUM_CORES (8 edges after Start at the default).
- No valid slot: MinSAD=all ones, MinRow=0, MinCol=0, AnyValid=0; OutValid still asserts.
- HOLD:
  - Outputs stay stable while OutReady is low.
  - At the accepting edge OutValid goes to 0, and MinSAD/MinRow/MinCol/AnyValid keep their values so the display persists.
- Busy = (state != IDLE).
- Back-to-back: Start may be sampled in the cycle immediately after handshake acceptance, i.e. in IDLE.

Optional Feature:
- SAD_EARLY_EXIT_EN defined:
  - In SCAN, if the slot being evaluated is valid with SAD==0, it is taken as the best and the state goes to HOLD at that same edge.
  - OutValid asserts the next cycle and the remaining slots are skipped.
- Not defined: every scan always takes exactly NUM_CORES evaluation cycles.

Test Plan:
- Distinct SADs:
  - Stimulus: all valid, SADs 100,90,80,70,35,60,50,40; all rows=3, cols=5; Start.
  - Response: OutValid 8 edges later, MinSAD=35, MinRow=35 (3+32), MinCol=5, AnyValid=1.
- Tie and invalid slot:
  - Stimulus: slot2 and slot5 SAD=20, others 50; slot0 SAD=1 with CoreValid[0]=0; row=1, col2=7, col5=9.
  - Response: MinSAD=20, MinRow=17, MinCol=7.
- No valid slots:
  - Stimulus: CoreValid=0; Start.
  - Response: OutValid=1, AnyValid=0, MinSAD=32'hFFFFFFFF, MinRow=0, MinCol=0.
- Backpressure:
  - Stimulus: OutReady low for 5 cycles in HOLD, Start pulsed and inputs changed meanwhile; then OutReady=1.
  - Response: outputs stable throughout; OutValid drops after acceptance; no second scan starts.
- Reset mid-scan and wrap:
  - Stimulus: Rst low at edge E+4.
  - Response: all outputs 0, IDLE.
  - Stimulus: new Start with only slot7 valid, row=250, SAD=9.
  - Response: MinRow=50 (mod 256), MinSAD=9.
- Early exit, with SAD_EARLY_EXIT_EN defined:
  - Stimulus: slot3 SAD=0 valid.
  - Response: OutValid 4 edges after Start, MinSAD=0.
  - Without the macro, the same stimulus gives OutValid after 8 edges.

Source files
------------

// File: rtl/sad_min_scanner.sv
// Serial minimum-SAD reducer: snapshots all core results on Start and scans one slot per clock.
// Optional SAD_EARLY_EXIT_EN: a valid zero SAD ends the scan at the slot where it is found.
module sad_min_scanner #(
  parameter int NUM_CORES  = 8,
  parameter int SAD_W      = 32,
  parameter int COORD_W    = 8,
  parameter int ROW_STRIDE = 8
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Start,
  input  logic [NUM_CORES*SAD_W-1:0]   CoreSAD,
  input  logic [NUM_CORES*COORD_W-1:0] CoreRow,
  input  logic [NUM_CORES*COORD_W-1:0] CoreCol,
  input  logic [NUM_CORES-1:0]         CoreValid,
  input  logic                         OutReady,
  output logic                         OutValid,
  output logic [SAD_W-1:0]             MinSAD,
  output logic [COORD_W-1:0]           MinRow,
  output logic [COORD_W-1:0]           MinCol,
  output logic                         AnyValid,
  output logic                         Busy
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;

  logic [NUM_CORES*SAD_W-1:0]   r_snap_sad;
  logic [NUM_CORES*COORD_W-1:0] r_snap_row;
  logic [NUM_CORES*COORD_W-1:0] r_snap_col;
  logic [NUM_CORES-1:0]         r_snap_valid;
  logic [IDX_W-1:0]             r_idx;
  logic [SAD_W-1:0]             r_best;
  logic [COORD_W-1:0]           r_best_row;
  logic [COORD_W-1:0]           r_best_col;
  logic                         r_found;

  logic                         r_out_valid;
  logic [SAD_W-1:0]             r_min_sad;
  logic [COORD_W-1:0]           r_min_row;
  logic [COORD_W-1:0]           r_min_col;
  logic                         r_any_valid;
  logic                         r_busy;

  logic [SAD_W-1:0]             w_slot_sad;
  logic [COORD_W-1:0]           w_slot_row;
  logic [COORD_W-1:0]           w_slot_col;
  logic                         w_slot_valid;
  logic [COORD_W-1:0]           w_row_glb;
  logic                         w_take;
  logic                         w_last;
  logic                         w_early;
  logic                         w_accept;
  logic [SAD_W-1:0]             w_best_nxt;
  logic [COORD_W-1:0]           w_best_row_nxt;
  logic [COORD_W-1:0]           w_best_col_nxt;
  logic                         w_found_nxt;

  assign w_slot_sad   = r_snap_sad[r_idx*SAD_W +: SAD_W];
  assign w_slot_row   = r_snap_row[r_idx*COORD_W +: COORD_W];
  assign w_slot_col   = r_snap_col[r_idx*COORD_W +: COORD_W];
  assign w_slot_valid = r_snap_valid[r_idx];
  // Global row wraps modulo 2^COORD_W by construction of the adder width.
  assign w_row_glb    = w_slot_row + (COORD_W'(r_idx) * COORD_W'(ROW_STRIDE));

  // Strict less-than keeps the lower index on ties.
  assign w_take         = w_slot_valid && (!r_found || (w_slot_sad < r_best));
  assign w_best_nxt     = w_take ? w_slot_sad : r_best;
  assign w_best_row_nxt = w_take ? w_row_glb  : r_best_row;
  assign w_best_col_nxt = w_take ? w_slot_col : r_best_col;
  assign w_found_nxt    = w_take | r_found;
  assign w_last         = (r_idx == IDX_W'(NUM_CORES - 1));
  assign w_accept       = r_out_valid && OutReady;

`ifdef SAD_EARLY_EXIT_EN
  assign w_early = w_slot_valid && (w_slot_sad == {SAD_W{1'b0}});
`else
  assign w_early = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = Start ? ST_SCAN : ST_IDLE;
      ST_SCAN: w_state_nxt = (w_last || w_early) ? ST_HOLD : ST_SCAN;
      ST_HOLD: w_state_nxt = w_accept ? ST_IDLE : ST_HOLD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot, running minimum and registered result.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_snap_sad   <= {(NUM_CORES*SAD_W){1'b0}};
      r_snap_row   <= {(NUM_CORES*COORD_W){1'b0}};
      r_snap_col   <= {(NUM_CORES*COORD_W){1'b0}};
      r_snap_valid <= {NUM_CORES{1'b0}};
      r_idx        <= {IDX_W{1'b0}};
      r_best       <= {SAD_W{1'b0}};
      r_best_row   <= {COORD_W{1'b0}};
      r_best_col   <= {COORD_W{1'b0}};
      r_found      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_min_sad    <= {SAD_W{1'b0}};
      r_min_row    <= {COORD_W{1'b0}};
      r_min_col    <= {COORD_W{1'b0}};
      r_any_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_snap_sad   <= CoreSAD;
            r_snap_row   <= CoreRow;
            r_snap_col   <= CoreCol;
            r_snap_valid <= CoreValid;
            r_idx        <= {IDX_W{1'b0}};
            r_best       <= {SAD_W{1'b1}};
            r_best_row   <= {COORD_W{1'b0}};
            r_best_col   <= {COORD_W{1'b0}};
            r_found      <= 1'b0;
          end
        end
        ST_SCAN: begin
          r_best     <= w_best_nxt;
          r_best_row <= w_best_row_nxt;
          r_best_col <= w_best_col_nxt;
          r_found    <= w_found_nxt;
          r_idx      <= r_idx + IDX_W'(1);
          if (w_last || w_early) begin
            r_min_sad   <= w_best_nxt;
            r_min_row   <= w_best_row_nxt;
            r_min_col   <= w_best_col_nxt;
            r_any_valid <= w_found_nxt;
            r_out_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          // Result fields are left untouched so the display persists after acceptance.
          if (w_accept) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign OutValid = r_out_valid;
  assign MinSAD   = r_min_sad;
  assign MinRow   = r_min_row;
  assign MinCol   = r_min_col;
  assign AnyValid = r_any_valid;
  assign Busy     = r_busy;

endmodule

// File: tb/tb_sad_min_scanner.sv
// Directed bench for sad_min_scanner with hand-computed expected results.
module tb_sad_min_scanner;

  localparam int NC = 8;
  localparam int SW = 32;
  localparam int CW = 8;
`ifdef SAD_EARLY_EXIT_EN
  localparam int EXIT_LAT = 4;
`else
  localparam int EXIT_LAT = 8;
`endif

  logic           Clk = 1'b0;
  logic           Rst;
  logic           Start;
  logic [NC*SW-1:0] CoreSAD;
  logic [NC*CW-1:0] CoreRow;
  logic [NC*CW-1:0] CoreCol;
  logic [NC-1:0]  CoreValid;
  logic           OutReady;
  logic           OutValid;
  logic [SW-1:0]  MinSAD;
  logic [CW-1:0]  MinRow;
  logic [CW-1:0]  MinCol;
  logic           AnyValid;
  logic           Busy;

  int n_vec = 0;
  int n_err = 0;

  sad_min_scanner dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .CoreSAD(CoreSAD), .CoreRow(CoreRow), .CoreCol(CoreCol), .CoreValid(CoreValid),
    .OutReady(OutReady), .OutValid(OutValid), .MinSAD(MinSAD), .MinRow(MinRow),
    .MinCol(MinCol), .AnyValid(AnyValid), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [SW-1:0] sad, input logic [CW-1:0] row,
                          input logic [CW-1:0] col, input logic vld);
    CoreSAD[i*SW +: SW] = sad;
    CoreRow[i*CW +: CW] = row;
    CoreCol[i*CW +: CW] = col;
    CoreValid[i]        = vld;
  endtask

  // Pulses Start, then counts edges until OutValid, bounded.
  task automatic run_scan(input string tag, input int exp_lat);
    int n;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 0;
    while (!OutValid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic check_result(input string tag, input logic [SW-1:0] sad, input logic [CW-1:0] row,
                              input logic [CW-1:0] col, input logic any);
    chk({tag, "_valid"}, 64'(OutValid), 64'd1);
    chk({tag, "_sad"},   64'(MinSAD),   64'(sad));
    chk({tag, "_row"},   64'(MinRow),   64'(row));
    chk({tag, "_col"},   64'(MinCol),   64'(col));
    chk({tag, "_any"},   64'(AnyValid), 64'(any));
    chk({tag, "_busy"},  64'(Busy),     64'd1);
  endtask

  task automatic accept(input string tag);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    chk({tag, "_drop"}, 64'(OutValid), 64'd0);
    chk({tag, "_idle"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; OutReady = 1'b0;
    CoreSAD = '0; CoreRow = '0; CoreCol = '0; CoreValid = '0;
    tick(); tick();
    chk("rst_valid", 64'(OutValid), 64'd0);
    chk("rst_busy",  64'(Busy),     64'd0);
    chk("rst_sad",   64'(MinSAD),   64'd0);
    Rst = 1'b1;
    tick();

    // Distinct SADs: slot4 wins, row 3 + 4*8.
    begin
      int sads [8] = '{100, 90, 80, 70, 35, 60, 50, 40};
      for (int i = 0; i < NC; i++) set_slot(i, SW'(sads[i]), 8'd3, 8'd5, 1'b1);
    end
    run_scan("dist", 8);
    check_result("dist", 32'd35, 8'd35, 8'd5, 1'b1);
    accept("dist_acc");
    chk("dist_persist", 64'(MinSAD), 64'd35);

    // Tie plus invalid low SAD, started back-to-back after acceptance.
    for (int i = 0; i < NC; i++) set_slot(i, 32'd50, 8'd1, 8'd0, 1'b1);
    set_slot(0, 32'd1, 8'd1, 8'd0, 1'b0);
    set_slot(2, 32'd20, 8'd1, 8'd7, 1'b1);
    set_slot(5, 32'd20, 8'd1, 8'd9, 1'b1);
    run_scan("tie", 8);
    check_result("tie", 32'd20, 8'd17, 8'd7, 1'b1);
    accept("tie_acc");

    // No valid slots.
    CoreValid = 8'h00;
    run_scan("none", 8);
    check_result("none", 32'hFFFF_FFFF, 8'd0, 8'd0, 1'b0);
    accept("none_acc");

    // Backpressure: outputs hold while Start and inputs toggle.
    for (int i = 0; i < NC; i++) set_slot(i, 32'd50, 8'd1, 8'd0, 1'b1);
    set_slot(2, 32'd20, 8'd1, 8'd7, 1'b1);
    run_scan("bp", 8);
    for (int c = 0; c < 5; c++) begin
      Start = (c == 2) ? 1'b1 : 1'b0;
      for (int i = 0; i < NC; i++) set_slot(i, 32'd0, 8'd9, 8'd9, 1'b1);
      tick();
      chk("bp_hold_valid", 64'(OutValid), 64'd1);
      chk("bp_hold_sad",   64'(MinSAD),   64'd20);
      chk("bp_hold_row",   64'(MinRow),   64'd17);
    end
    Start = 1'b0;
    accept("bp_acc");
    tick(); tick();
    chk("bp_no_rescan", 64'(Busy), 64'd0);
    chk("bp_no_valid",  64'(OutValid), 64'd0);

    // Reset at edge E+4 of a scan, then row wrap on slot 7.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick(); tick();
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    chk("mrst_valid", 64'(OutValid), 64'd0);
    chk("mrst_busy",  64'(Busy),     64'd0);
    chk("mrst_sad",   64'(MinSAD),   64'd0);
    chk("mrst_row",   64'(MinRow),   64'd0);
    chk("mrst_col",   64'(MinCol),   64'd0);
    chk("mrst_any",   64'(AnyValid), 64'd0);
    tick(); tick();
    chk("mrst_stay_idle", 64'(Busy), 64'd0);
    for (int i = 0; i < NC; i++) set_slot(i, 32'd1, 8'd0, 8'd0, 1'b0);
    set_slot(7, 32'd9, 8'd250, 8'd4, 1'b1);
    run_scan("wrap", 8);
    check_result("wrap", 32'd9, 8'd50, 8'd4, 1'b1);
    accept("wrap_acc");

    // Zero SAD at slot 3: early exit only when the option is built in.
    for (int i = 0; i < NC; i++) set_slot(i, 32'd10, 8'd2, 8'd1, 1'b1);
    set_slot(3, 32'd0, 8'd2, 8'd6, 1'b1);
    run_scan("zero", EXIT_LAT);
    check_result("zero", 32'd0, 8'd26, 8'd6, 1'b1);
    accept("zero_acc");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
